// File: rtl/mul_acc_collect.sv
// mul_acc_collect: collects N_SAMPLES signed products per batch into a
// signed ACC_W-bit running sum. A capture happens on each rising edge of
// prod_valid. Overflow is sticky per batch in ovf.
// Optional feature macro ACC_SAT_EN: when defined, an overflowing add clamps
// to the most positive or most negative ACC_W-bit value. When it is not
// defined, an overflowing add wraps two's-complement.
module mul_acc_collect #(
    parameter int unsigned N_SAMPLES = 4,
    parameter int unsigned ACC_W     = 36
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [31:0]      prod_in,
    input  logic             prod_valid,
    input  logic             clr,
    output logic [ACC_W-1:0] acc_out,
    output logic [7:0]       sample_cnt,
    output logic             done,
    output logic             busy,
    output logic             ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [7:0] N_LAST = 8'(N_SAMPLES);

    state_t           state_q;
    logic             prev_valid_q;
    logic [ACC_W-1:0] acc_q;
    logic [7:0]       cnt_q;
    logic             done_q;
    logic             busy_q;
    logic             ovf_q;

    logic             capture_d;
    logic [ACC_W-1:0] ext_d;
    logic [ACC_W-1:0] raw_sum_d;
    logic [ACC_W-1:0] sum_d;
    logic             ovf_now_d;
    logic [7:0]       cnt_d;
    logic             last_d;

`ifdef ACC_SAT_EN
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

    // Edge detect, sign extension, add with overflow check, next-count decode
    always_comb begin
        capture_d = prod_valid & ~prev_valid_q;
        ext_d     = {{(ACC_W-32){prod_in[31]}}, prod_in};
        raw_sum_d = acc_q + ext_d;
        ovf_now_d = (acc_q[ACC_W-1] == ext_d[ACC_W-1]) &&
                    (raw_sum_d[ACC_W-1] != acc_q[ACC_W-1]);
`ifdef ACC_SAT_EN
        sum_d = raw_sum_d;
        if (ovf_now_d) begin
            sum_d = acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX;
        end
`else
        sum_d = raw_sum_d;
`endif
        cnt_d  = (state_q == ACCUM) ? (cnt_q + 8'd1) : 8'd1;
        last_d = (cnt_d == N_LAST);
    end

    // Batch FSM with registered outputs; clr outranks a same-cycle capture
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            prev_valid_q <= 1'b0;
            acc_q        <= '0;
            cnt_q        <= '0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            // Tracked even during clr so a held-high valid cannot capture afterwards
            prev_valid_q <= prod_valid;
            done_q       <= 1'b0;
            if (clr) begin
                state_q <= IDLE;
                acc_q   <= '0;
                cnt_q   <= '0;
                busy_q  <= 1'b0;
                ovf_q   <= 1'b0;
            end else if (capture_d) begin
                cnt_q <= cnt_d;
                if (state_q == ACCUM) begin
                    acc_q <= sum_d;
                    ovf_q <= ovf_q | ovf_now_d;
                end else begin
                    acc_q <= ext_d;
                    ovf_q <= 1'b0;
                end
                if (last_d) begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                end else begin
                    state_q <= ACCUM;
                    busy_q  <= 1'b1;
                end
            end
        end
    end

    assign acc_out    = acc_q;
    assign sample_cnt = cnt_q;
    assign done       = done_q;
    assign busy       = busy_q;
    assign ovf        = ovf_q;

endmodule
